// File: rtl/lsu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lsu_ctrl_pkg
//   Shared definitions for the load/store controller:
//   - DMType access codes, identical to the data-memory path encoding
//   - LSU FSM state encoding
//   - registered request record
//   - helpers that decode a DMType into access size and signedness
// -----------------------------------------------------------------------------
package lsu_ctrl_pkg;

  // DMType codes. Codes 101..111 are illegal and reported as errors.
  typedef enum logic [2:0] {
    DM_WORD          = 3'b000,
    DM_HALF          = 3'b001,
    DM_HALF_UNSIGNED = 3'b010,
    DM_BYTE          = 3'b011,
    DM_BYTE_UNSIGNED = 3'b100
  } dm_type_e;

  // LSU controller states.
  typedef enum logic [2:0] {
    LSU_IDLE = 3'd0,
    LSU_ACC0 = 3'd1,
    LSU_ACC1 = 3'd2,
    LSU_LAST = 3'd3,
    LSU_RESP = 3'd4
  } lsu_state_e;

  // Request fields frozen at accept time. The word address is kept
  // separately because its width depends on the instance parameter.
  typedef struct packed {
    logic        we;
    logic [2:0]  dm_type;
    logic [1:0]  off;
    logic        split;
    logic [31:0] wdata;
  } lsu_req_t;

  // Access size in bytes; 0 marks an illegal DMType.
  function automatic logic [2:0] dm_size(input logic [2:0] dm_type);
    logic [2:0] size;
    case (dm_type)
      DM_WORD:                   size = 3'd4;
      DM_HALF, DM_HALF_UNSIGNED: size = 3'd2;
      DM_BYTE, DM_BYTE_UNSIGNED: size = 3'd1;
      default:                   size = 3'd0;
    endcase
    return size;
  endfunction

  // Loads of these types are sign-extended; all others are zero-extended.
  function automatic logic dm_signed(input logic [2:0] dm_type);
    return (dm_type == DM_HALF) || (dm_type == DM_BYTE);
  endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// -----------------------------------------------------------------------------
// lsu_align
//   Purely combinational data alignment for the LSU.
//   Store path: builds the 8-lane byte mask and the 64-bit lane-aligned data
//   spanning two consecutive RAM words from (dm_type, off, wdata).
//   Load path: extracts the addressed bytes from the two-word window
//   {w1, w0} and sign/zero-extends them according to dm_type.
//
// Ports
//   dm_type  in  3   DMType of the access
//   off      in  2   byte offset inside the first word
//   wdata    in  32  right-justified store data
//   rdata64  in  64  {w1, w0} read window (w1 = 0 when not split)
//   st_mask  out 8   byte enables; [3:0] first word, [7:4] second word
//   st_data  out 64  shifted store data; [31:0] first word, [63:32] second
//   ld_data  out 32  extended load result
// -----------------------------------------------------------------------------
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [2:0]  dm_type,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [63:0] rdata64,
  output logic [7:0]  st_mask,
  output logic [63:0] st_data,
  output logic [31:0] ld_data
);

  logic [2:0]  size;
  logic [7:0]  base_mask;
  logic [31:0] window;

  // NOTE: every output of a combinational block gets a value before any
  // branch so that no path leaves it unassigned (which would infer a latch).
  always_comb begin
    size      = dm_size(dm_type);
    base_mask = 8'h00;
    ld_data   = 32'h0;

    case (size)
      3'd4:    base_mask = 8'h0F;
      3'd2:    base_mask = 8'h03;
      3'd1:    base_mask = 8'h01;
      default: base_mask = 8'h00;
    endcase

    st_mask = base_mask << off;
    st_data = {32'h0, wdata} << {off, 3'b000};

    // Only the low 32 bits of the right-shifted window can be addressed.
    window = 32'(rdata64 >> {off, 3'b000});

    case (size)
      3'd4: ld_data = window;
      3'd2: ld_data = dm_signed(dm_type) ? {{16{window[15]}}, window[15:0]}
                                         : {16'h0, window[15:0]};
      3'd1: ld_data = dm_signed(dm_type) ? {{24{window[7]}}, window[7:0]}
                                         : {24'h0, window[7:0]};
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
//   Load/store controller between the CPU memory stage and a word-wide,
//   byte-enabled synchronous data RAM. Accepts one request per handshake,
//   splits word-crossing accesses into two RAM accesses, assembles load data
//   little-endian with sign/zero extension and returns a one-cycle response.
//
// Parameters
//   ADDR_W      RAM word-address width (legal bytes 0 .. 4*2^ADDR_W-1)
//
// Ports
//   clk, rst    clock; synchronous active-high reset
//   req_*       request handshake (valid/ready), we, byte addr, wdata, DMType
//   resp_*      one-cycle completion pulse with load data and error flag
//   mem_*       RAM port: enable, write, word address, byte enables, data;
//               mem_rdata is valid the cycle after a read
// -----------------------------------------------------------------------------
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_type,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // Highest legal byte address, widened so the end-of-access sum never wraps.
  localparam logic [32:0] MAX_BYTE = (33'd4 << ADDR_W) - 33'd1;

  lsu_state_e        state_q,      state_d;
  lsu_req_t          req_q,        req_d;
  logic [ADDR_W-1:0] w0_q,         w0_d;
  logic [31:0]       buf_q,        buf_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q,   resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  // Decode of the incoming request, used only at accept.
  logic [2:0]  in_size;
  logic [32:0] in_last;
  logic        in_err;
  logic        in_split;

  // Alignment datapath, always driven from the registered request.
  logic [63:0] rdata64;
  logic [7:0]  st_mask;
  logic [63:0] st_data;
  logic [31:0] ld_data;

  always_comb begin
    in_size  = dm_size(req_type);
    in_last  = {1'b0, req_addr} + {30'h0, in_size} - 33'd1;
    in_err   = (in_size == 3'd0) || (in_last > MAX_BYTE);
    in_split = ({1'b0, req_addr[1:0]} + in_size) > 3'd4;
  end

  // For a split load the first word was parked in buf_q during ACC1 and
  // mem_rdata carries the second word in LAST; otherwise mem_rdata is w0.
  assign rdata64 = req_q.split ? {mem_rdata, buf_q} : {32'h0, mem_rdata};

  lsu_align u_align (
    .dm_type (req_q.dm_type),
    .off     (req_q.off),
    .wdata   (req_q.wdata),
    .rdata64 (rdata64),
    .st_mask (st_mask),
    .st_data (st_data),
    .ld_data (ld_data)
  );

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic.
  // resp_* registers are loaded on the transition into RESP and fall back to
  // zero on the way out, so they hold steady for the RESP cycle only.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    w0_d         = w0_q;
    buf_d        = buf_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;

    unique case (state_q)
      LSU_IDLE: begin
        // req_ready is high throughout IDLE outside reset, and reset
        // overrides this transition in the register block.
        if (req_valid) begin
          req_d.we      = req_we;
          req_d.dm_type = req_type;
          req_d.off     = req_addr[1:0];
          req_d.split   = in_split;
          req_d.wdata   = req_wdata;
          w0_d          = req_addr[ADDR_W+1:2];
          if (in_err) begin
            state_d      = LSU_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d = LSU_ACC0;
          end
        end
      end

      LSU_ACC0: begin
        if (req_q.split) begin
          state_d = LSU_ACC1;
        end else if (req_q.we) begin
          state_d      = LSU_RESP;
          resp_valid_d = 1'b1;
        end else begin
          state_d = LSU_LAST;
        end
      end

      LSU_ACC1: begin
        if (req_q.we) begin
          state_d      = LSU_RESP;
          resp_valid_d = 1'b1;
        end else begin
          buf_d   = mem_rdata;
          state_d = LSU_LAST;
        end
      end

      LSU_LAST: begin
        resp_rdata_d = ld_data;
        resp_valid_d = 1'b1;
        state_d      = LSU_RESP;
      end

      LSU_RESP: begin
        state_d = LSU_IDLE;
      end

      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LSU_IDLE;
      req_q        <= '0;
      w0_q         <= '0;
      buf_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      w0_q         <= w0_d;
      buf_q        <= buf_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Everything is masked while rst is high so that a reset cycle can
  // never issue a RAM write (e.g. the second half of an interrupted split).
  // ---------------------------------------------------------------------------
  assign req_ready  = (state_q == LSU_IDLE) && !rst;
  assign resp_valid = resp_valid_q && !rst;
  assign resp_err   = resp_err_q && !rst;
  assign resp_rdata = rst ? 32'h0 : resp_rdata_q;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'h0;
    mem_wdata = 32'h0;
    if (!rst) begin
      if (state_q == LSU_ACC0) begin
        mem_en    = 1'b1;
        mem_we    = req_q.we;
        mem_addr  = w0_q;
        mem_be    = st_mask[3:0];
        mem_wdata = req_q.we ? st_data[31:0] : 32'h0;
      end else if (state_q == LSU_ACC1) begin
        mem_en    = 1'b1;
        mem_we    = req_q.we;
        mem_addr  = w0_q + ADDR_W'(1);
        mem_be    = st_mask[7:4];
        mem_wdata = req_q.we ? st_data[63:32] : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl
//   Self-checking bench for lsu_ctrl with a byte-enabled synchronous RAM,
//   a directed vector table, a mid-split reset sequence and randomized
//   traffic compared against a byte-array reference model.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

  localparam int ADDR_W  = 7;
  localparam int NWORDS  = 1 << ADDR_W;
  localparam int NBYTES  = 4 * NWORDS;
  localparam int N_RAND  = 300;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_type;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_type   (req_type),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous byte-enabled RAM: read data appears the cycle after mem_en.
  logic        ram_clear;
  logic [31:0] ram [NWORDS];

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < NWORDS; i++) ram[i] <= 32'h0;
      mem_rdata <= 32'h0;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= ram[mem_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Scoring
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a flat little-endian byte array.
  // ---------------------------------------------------------------------------
  logic [7:0] mdl [NBYTES];

  function automatic int type_size(input logic [2:0] t);
    case (t)
      3'b000:         return 4;
      3'b001, 3'b010: return 2;
      3'b011, 3'b100: return 1;
      default:        return 0;
    endcase
  endfunction

  task automatic model_access(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] typ,
                              output logic [31:0] rd, output logic err,
                              output int lat, output int nacc);
    int s;
    int base;
    bit split;
    s    = type_size(typ);
    rd   = 32'h0;
    err  = (s == 0) || ({32'h0, addr} + 64'(s) - 64'd1 > 64'(NBYTES - 1));
    lat  = 1;
    nacc = 0;
    if (!err) begin
      base  = int'(addr);
      split = (base % 4) + s > 4;
      nacc  = split ? 2 : 1;
      if (we) begin
        for (int i = 0; i < s; i++) mdl[base + i] = wdata[8*i +: 8];
        lat = split ? 3 : 2;
      end else begin
        for (int i = 0; i < s; i++) rd[8*i +: 8] = mdl[base + i];
        if (typ == 3'b001 && rd[15]) rd = rd | 32'hFFFF_0000;
        if (typ == 3'b011 && rd[7])  rd = rd | 32'hFFFF_FF00;
        lat = split ? 4 : 3;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction driver. Starts and ends on a falling edge. Records every RAM
  // access seen before the response and the response latency in cycles.
  // ---------------------------------------------------------------------------
  int                n_acc;
  logic [ADDR_W-1:0] acc_addr [4];
  logic [3:0]        acc_be   [4];
  logic [31:0]       acc_wd   [4];
  logic              acc_we   [4];

  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] typ,
                        output logic [31:0] rd, output logic err, output int lat);
    int k;
    n_acc = 0;
    rd    = 32'h0;
    err   = 1'b0;
    lat   = -1;
    k     = 0;
    while (!req_ready && k < 16) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_wait", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_type  = typ;
    @(posedge clk);
    @(negedge clk);
    // Scramble the request after accept; it must have no effect.
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_type  = 3'($urandom);
    for (int c = 1; c <= 12; c++) begin
      if (mem_en && n_acc < 4) begin
        acc_addr[n_acc] = mem_addr;
        acc_be[n_acc]   = mem_be;
        acc_wd[n_acc]   = mem_wdata;
        acc_we[n_acc]   = mem_we;
        n_acc++;
      end
      if (resp_valid) begin
        lat = c;
        rd  = resp_rdata;
        err = resp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic              we;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [2:0]        typ;
    logic [31:0]       exp_rd;
    logic              exp_err;
    int                exp_lat;
    int                exp_nacc;
    logic [ADDR_W-1:0] a0;
    logic [3:0]        be0;
    logic [31:0]       wd0;
    logic [ADDR_W-1:0] a1;
    logic [3:0]        be1;
    logic [31:0]       wd1;
  } vec_t;

  localparam int N_VEC = 18;
  vec_t vecs [N_VEC];

  function automatic vec_t mk(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] typ,
                              input logic [31:0] exp_rd, input logic exp_err,
                              input int exp_lat, input int exp_nacc,
                              input int a0, input logic [3:0] be0, input logic [31:0] wd0,
                              input int a1, input logic [3:0] be1, input logic [31:0] wd1);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.typ = typ;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_nacc = exp_nacc;
    v.a0 = ADDR_W'(a0); v.be0 = be0; v.wd0 = wd0;
    v.a1 = ADDR_W'(a1); v.be1 = be1; v.wd1 = wd1;
    return v;
  endfunction

  initial begin
    logic [31:0] rd, m_rd;
    logic        err, m_err;
    int          lat, m_lat, m_nacc;

    //             we    addr      wdata         typ     exp_rd        err lat nacc a0  be0    wd0            a1  be1    wd1
    vecs[0]  = mk(1'b1, 32'h010, 32'h11223344, 3'b000, 32'h0,        0, 2, 1,   4, 4'hF, 32'h11223344, 0,  4'h0, 32'h0);
    vecs[1]  = mk(1'b0, 32'h010, 32'hDEADBEEF, 3'b000, 32'h11223344, 0, 3, 1,   4, 4'h0, 32'h0,        0,  4'h0, 32'h0);
    vecs[2]  = mk(1'b1, 32'h021, 32'h00000080, 3'b011, 32'h0,        0, 2, 1,   8, 4'h2, 32'h00008000, 0,  4'h0, 32'h0);
    vecs[3]  = mk(1'b0, 32'h021, 32'h0,        3'b011, 32'hFFFFFF80, 0, 3, 1,   8, 4'h0, 32'h0,        0,  4'h0, 32'h0);
    vecs[4]  = mk(1'b0, 32'h021, 32'h0,        3'b100, 32'h00000080, 0, 3, 1,   8, 4'h0, 32'h0,        0,  4'h0, 32'h0);
    vecs[5]  = mk(1'b1, 32'h013, 32'hAABBCCDD, 3'b000, 32'h0,        0, 3, 2,   4, 4'h8, 32'hDD000000, 5,  4'h7, 32'h00AABBCC);
    vecs[6]  = mk(1'b0, 32'h013, 32'h0,        3'b000, 32'hAABBCCDD, 0, 4, 2,   4, 4'h0, 32'h0,        5,  4'h0, 32'h0);
    vecs[7]  = mk(1'b1, 32'h01F, 32'hFFFFFF34, 3'b011, 32'h0,        0, 2, 1,   7, 4'h8, 32'h34000000, 0,  4'h0, 32'h0);
    vecs[8]  = mk(1'b1, 32'h020, 32'h000000F2, 3'b011, 32'h0,        0, 2, 1,   8, 4'h1, 32'h000000F2, 0,  4'h0, 32'h0);
    vecs[9]  = mk(1'b0, 32'h01F, 32'h0,        3'b001, 32'hFFFFF234, 0, 4, 2,   7, 4'h0, 32'h0,        8,  4'h0, 32'h0);
    vecs[10] = mk(1'b0, 32'h01F, 32'h0,        3'b010, 32'h0000F234, 0, 4, 2,   7, 4'h0, 32'h0,        8,  4'h0, 32'h0);
    vecs[11] = mk(1'b0, 32'h000, 32'h0,        3'b111, 32'h0,        1, 1, 0,   0, 4'h0, 32'h0,        0,  4'h0, 32'h0);
    vecs[12] = mk(1'b0, 32'h1FE, 32'h0,        3'b000, 32'h0,        1, 1, 0,   0, 4'h0, 32'h0,        0,  4'h0, 32'h0);
    vecs[13] = mk(1'b1, 32'h1FF, 32'h0000005A, 3'b011, 32'h0,        0, 2, 1, 127, 4'h8, 32'h5A000000, 0,  4'h0, 32'h0);
    vecs[14] = mk(1'b1, 32'h1FF, 32'h00001234, 3'b001, 32'h0,        1, 1, 0,   0, 4'h0, 32'h0,        0,  4'h0, 32'h0);
    vecs[15] = mk(1'b0, 32'h1FF, 32'h0,        3'b100, 32'h0000005A, 0, 3, 1, 127, 4'h0, 32'h0,        0,  4'h0, 32'h0);
    vecs[16] = mk(1'b0, 32'h1FE, 32'h0,        3'b001, 32'h00005A00, 0, 3, 1, 127, 4'h0, 32'h0,        0,  4'h0, 32'h0);
    vecs[17] = mk(1'b1, 32'h022, 32'h1234BEEF, 3'b001, 32'h0,        0, 2, 1,   8, 4'hC, 32'hBEEF0000, 0,  4'h0, 32'h0);

    for (int i = 0; i < NBYTES; i++) mdl[i] = 8'h0;

    // ---- reset ----
    rst       = 1'b1;
    ram_clear = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_type  = 3'b000;
    repeat (3) @(negedge clk);
    check("reset_mem_outputs", 64'({mem_en, mem_we, mem_addr, mem_be, mem_wdata}), 64'd0);
    check("reset_resp_outputs", 64'({req_ready, resp_valid, resp_err, resp_rdata}), 64'd0);
    rst       = 1'b0;
    ram_clear = 1'b0;
    @(negedge clk);
    check("post_reset_ready", 64'(req_ready), 64'd1);
    check("post_reset_idle", 64'({resp_valid, mem_en}), 64'd0);

    // ---- directed table ----
    for (int i = 0; i < N_VEC; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].typ, rd, err, lat);
      model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].typ, m_rd, m_err, m_lat, m_nacc);
      check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
      check($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("vec%0d_num_access", i), 64'(n_acc), 64'(vecs[i].exp_nacc));
      if (n_acc >= 1 && vecs[i].exp_nacc >= 1) begin
        check($sformatf("vec%0d_acc0_addr", i), 64'(acc_addr[0]), 64'(vecs[i].a0));
        check($sformatf("vec%0d_acc0_we", i), 64'(acc_we[0]), 64'(vecs[i].we));
        if (vecs[i].we) begin
          check($sformatf("vec%0d_acc0_be", i), 64'(acc_be[0]), 64'(vecs[i].be0));
          check($sformatf("vec%0d_acc0_wdata", i), 64'(acc_wd[0]), 64'(vecs[i].wd0));
        end
      end
      if (n_acc >= 2 && vecs[i].exp_nacc >= 2) begin
        check($sformatf("vec%0d_acc1_addr", i), 64'(acc_addr[1]), 64'(vecs[i].a1));
        if (vecs[i].we) begin
          check($sformatf("vec%0d_acc1_be", i), 64'(acc_be[1]), 64'(vecs[i].be1));
          check($sformatf("vec%0d_acc1_wdata", i), 64'(acc_wd[1]), 64'(vecs[i].wd1));
        end
      end
    end

    // ---- reset during ACC1 of a split store @0x13 ----
    // Word 4 currently holds 0xDD223344, word 5 holds 0x00AABBCC.
    @(negedge clk);
    check("split_rst_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h013;
    req_wdata = 32'h01020304;
    req_type  = 3'b000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("split_rst_acc0", 64'({mem_en, mem_we, mem_addr}), 64'({1'b1, 1'b1, 7'd4}));
    @(negedge clk);
    check("split_rst_acc1", 64'({mem_en, mem_we, mem_addr}), 64'({1'b1, 1'b1, 7'd5}));
    rst = 1'b1;
    #1;
    check("split_rst_mem_zero", 64'({mem_en, mem_we, mem_addr, mem_be, mem_wdata}), 64'd0);
    check("split_rst_resp_zero", 64'({req_ready, resp_valid, resp_err, resp_rdata}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("split_rst_ready_after", 64'(req_ready), 64'd1);
    check("split_rst_word4", 64'(ram[4]), 64'h04223344);
    check("split_rst_word5", 64'(ram[5]), 64'h00AABBCC);
    mdl[32'h13] = 8'h04;
    do_req(1'b0, 32'h010, 32'h0, 3'b000, rd, err, lat);
    check("split_rst_lw_rdata", 64'(rd), 64'h04223344);
    check("split_rst_lw_err", 64'(err), 64'd0);
    check("split_rst_lw_latency", 64'(lat), 64'd3);

    // ---- randomized traffic against the byte-array model ----
    for (int n = 0; n < N_RAND; n++) begin
      logic        r_we;
      logic [31:0] r_addr, r_wdata;
      logic [2:0]  r_typ;
      r_we    = 1'($urandom);
      r_addr  = 32'($urandom_range(0, 32'h20F));
      r_wdata = $urandom;
      r_typ   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                            : 3'($urandom_range(0, 4));
      do_req(r_we, r_addr, r_wdata, r_typ, rd, err, lat);
      model_access(r_we, r_addr, r_wdata, r_typ, m_rd, m_err, m_lat, m_nacc);
      check($sformatf("rand%0d_rdata", n), 64'(rd), 64'(m_rd));
      check($sformatf("rand%0d_err", n), 64'(err), 64'(m_err));
      check($sformatf("rand%0d_latency", n), 64'(lat), 64'(m_lat));
      check($sformatf("rand%0d_num_access", n), 64'(n_acc), 64'(m_nacc));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
